axil_gpio_regbank: RTL
======================

Name: axil_gpio_regbank

Overview:
- Parametrised AXI3-lite register-bank slave, the successor of the single-register LED slave on the HPS lightweight H2F bridge.
- Adds configurable register count and output/input widths, proper ID echo on B and R, SLVERR decode and byte strobes.
- Adds synchronised input capture, sticky W1C edge events and a maskable interrupt for the f2h IRQ lines.
- Sits between the lightweight bridge master and board I/O (LEDs, keys).

Parameters:
ADDR_W, 21, AXI address width
ID_W, 12, AXI transaction ID width
NUM_REGS, 8, number of 32-bit registers (min 5)
OUT_W, 8, width of out_o (max 32)
IN_W, 2, width of in_i (max 32)
VERSION, 32'h0001_0000, value of read-only ID register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_axil_awid/awaddr/awprot/awvalid  in  ID_W/ADDR_W/3/1  write address channel
s_axil_awready  out  1
s_axil_wdata/wstrb/wvalid  in  32/4/1  write data channel
s_axil_wready  out  1
s_axil_bid/bresp/bvalid  out  ID_W/2/1  write response
s_axil_bready  in  1
s_axil_arid/araddr/arprot/arvalid  in  ID_W/ADDR_W/3/1  read address channel
s_axil_arready  out  1
s_axil_rid/rdata/rresp/rlast/rvalid  out  ID_W/32/2/1/1  read data channel
s_axil_rready  in  1
out_o  out  OUT_W  driven outputs (LEDs)
in_i  in  IN_W  asynchronous inputs (keys)
irq_o  out  1  level interrupt, registered

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: every register is 0; awready=1, wready=1, arready=1; bvalid=0, rvalid=0; bid/rid/rdata/bresp/rresp=0; out_o=0; irq_o=0; synchroniser flops are 0.
- Register index is addr[ADDR_W-1:2]; addr[1:0] and prot are ignored.
- Register map:
  - 0 OUT (RW): out_o = reg[OUT_W-1:0].
  - 1 IN (RO): synchronised in_i, zero-extended.
  - 2 EVENT (W1C): sticky rising edges of synchronised in_i.
  - 3 ID (RO): VERSION.
  - 4 IRQ_MASK (RW).
  - 5..NUM_REGS-1: scratch (RW).
  - Only the implemented bits of RW registers are stored; unimplemented bits read 0.
- Write path:
  - AW and W are accepted independently into one-deep holding slots; awready=!aw_held, wready=!w_held.
  - Commit occurs in the cycle where aw_held & w_held & !bvalid.
  - On commit, bytes are written per wstrb. Both slots clear, so awready and wready re-assert next cycle. bvalid rises next cycle with bid = held awid.
  - bresp = SLVERR (2'b10) if index >= NUM_REGS, with no state change; otherwise OKAY.
  - Writes to RO registers return OKAY and are ignored.
  - bvalid, bid and bresp hold stable until bready.
  - Minimum throughput is one write per 2 cycles with bready=1.
- Read path:
  - arready = !rvalid.
  - On an AR handshake, rvalid rises next cycle with rdata registered from the current register value, rid = arid and rlast = 1.
  - Out-of-range reads return rdata=0 and rresp=SLVERR.
  - rvalid, rid, rdata, rresp and rlast hold until rready.
  - Reads have no side effects, including on EVENT.
- Inputs:
  - in_i passes through a 2-flop synchroniser; IN reflects the second flop.
  - A rising edge is sync2 & ~sync3 (third flop); it sets the EVENT bit in the next cycle.
  - Edge to EVENT visibility is 3 cycles.
- W1C rule: written 1s under wstrb clear EVENT bits. An edge arriving in the commit cycle wins, so the bit stays set.
- Interrupt: irq_o <= |(EVENT & IRQ_MASK), registered, which adds 1 cycle.
- Reads and writes proceed concurrently and independently. A read in the commit cycle returns the pre-write value.
- Bursts are not supported; the lightweight bridge issues single beats only. No awlen or wlast ports are provided.
- Reset assertion mid-transaction drops all held state immediately; no response is issued for in-flight transactions.

Decomposition:
- Package axil_gpio_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - register index constants REG_OUT..REG_SCRATCH0;
  - a function mapping wstrb to a 32-bit byte mask.
- One sub-module, sync_edge_detect (param W): 3-flop synchroniser producing level and rise outputs.

Test Plan:
- Reset, then write idx0 (addr 0x0) data 0xA5 strb 4'hF, awid 0x3 → bvalid in 1 cycle after commit; bid=0x3, bresp=OKAY, out_o=0xA5.
- Write addr 0x14 with wdata 0xDEADBEEF and strb 4'b0101, then read with arid 0x7 → rdata=0x00AD00EF, rid=0x7, rlast=1, rresp=OKAY.
- W presented 3 cycles before AW, with bready held 0 for 4 cycles → single commit; awready=0 while the slot is held; B stable until bready.
- Pulse in_i[1] for 5 cycles, IRQ_MASK=0x2 → EVENT=0x2 after 3 cycles, irq_o=1 one cycle later. Write 0x2 to EVENT → irq_o drops. An edge coinciding with the W1C commit leaves EVENT=0x2.
- Read and write to index NUM_REGS (addr 0x20) → rresp=bresp=SLVERR, rdata=0, no register change. Read ID → 0x0001_0000.
- Assert rst_n low during a held AW → all valids=0, out_o=0 asynchronously; the next transaction completes normally.

Source files
------------

// File: rtl/axil_gpio_pkg.sv
// ----------------------------------------------------------------------------
// axil_gpio_pkg
// Shared definitions for the AXI3-lite GPIO register bank:
//   - AXI response codes
//   - register index map
//   - strb_to_mask(): expands a 4-bit byte strobe into a 32-bit bit mask
// ----------------------------------------------------------------------------
package axil_gpio_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_OUT      = 0;
    localparam int REG_IN       = 1;
    localparam int REG_EVENT    = 2;
    localparam int REG_ID       = 3;
    localparam int REG_IRQ_MASK = 4;
    localparam int REG_SCRATCH0 = 5;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_gpio_regbank_sync.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
// Three-flop synchroniser for asynchronous board inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input bus (W bits)
//   level      : synchronised level (second flop)
//   rise       : one-cycle pulse per rising edge of level (second & ~third)
// ----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync_p0;
    logic [W-1:0] sync_p1;
    logic [W-1:0] sync_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            // stage 0: metastability capture
            sync_p0 <= d;
            // stage 1: settled level
            sync_p1 <= sync_p0;
            // stage 2: previous level, for edge detection
            sync_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~sync_p2;

endmodule

// File: rtl/axil_gpio_regbank.sv
// ----------------------------------------------------------------------------
// axil_gpio_regbank
// AXI3-lite register bank for the HPS lightweight bridge: LED outputs,
// synchronised key inputs, sticky W1C rising-edge events and a maskable
// registered interrupt.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*  : write address / data / response channels
//   s_axil_ar*/r*     : read address / data channels (single beat, rlast=1)
//   out_o             : OUT register, low OUT_W bits
//   in_i              : asynchronous inputs
//   irq_o             : |(EVENT & IRQ_MASK), registered
// Map: 0 OUT, 1 IN, 2 EVENT, 3 ID, 4 IRQ_MASK, 5.. scratch.
// ----------------------------------------------------------------------------
module axil_gpio_regbank
    import axil_gpio_pkg::*;
#(
    parameter int          ADDR_W   = 21,
    parameter int          ID_W     = 12,
    parameter int          NUM_REGS = 8,
    parameter int          OUT_W    = 8,
    parameter int          IN_W     = 2,
    parameter logic [31:0] VERSION  = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   s_axil_awid,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic [2:0]        s_axil_awprot,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [ID_W-1:0]   s_axil_bid,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ID_W-1:0]   s_axil_arid,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic [2:0]        s_axil_arprot,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [ID_W-1:0]   s_axil_rid,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rlast,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [OUT_W-1:0]  out_o,
    input  logic [IN_W-1:0]   in_i,
    output logic              irq_o
);

    localparam int IDX_W   = ADDR_W - 2;
    localparam int NUM_SCR = (NUM_REGS > REG_SCRATCH0) ? (NUM_REGS - REG_SCRATCH0) : 1;

    // Address low bits and protection are not decoded.
    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    logic              aw_held;
    logic              w_held;
    logic [ID_W-1:0]   aw_id_held;
    logic [IDX_W-1:0]  aw_idx_held;
    logic [31:0]       w_data_held;
    logic [3:0]        w_strb_held;

    logic [OUT_W-1:0]  out_reg;
    logic [IN_W-1:0]   mask_reg;
    logic [IN_W-1:0]   event_reg;
    logic [31:0]       scratch [NUM_SCR];

    logic [IN_W-1:0]   in_level;
    logic [IN_W-1:0]   in_rise;

    logic              commit;
    logic              wr_in_range;
    logic              wr_ok;
    logic [31:0]       wr_mask;
    logic [31:0]       wr_bits;
    logic [IN_W-1:0]   ev_clr;

    logic [IDX_W-1:0]  ar_idx;
    logic [31:0]       rd_data;
    logic              rd_err;

    sync_edge_detect #(.W(IN_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_i),
        .level (in_level),
        .rise  (in_rise)
    );

    assign s_axil_awready = !aw_held;
    assign s_axil_wready  = !w_held;
    assign s_axil_arready = !s_axil_rvalid;

    // A held write only commits once the previous response has been taken,
    // so B never has to queue more than one response.
    assign commit      = aw_held && w_held && !s_axil_bvalid;
    assign wr_in_range = aw_idx_held < IDX_W'(NUM_REGS);
    assign wr_ok       = commit && wr_in_range;
    assign wr_mask     = strb_to_mask(w_strb_held);
    assign wr_bits     = w_data_held & wr_mask;

    always_comb begin
        ev_clr = '0;
        if (wr_ok && aw_idx_held == IDX_W'(REG_EVENT)) begin
            ev_clr = wr_bits[IN_W-1:0];
        end
    end

    // Write holding slots and response channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_id_held    <= '0;
            aw_idx_held   <= '0;
            w_data_held   <= '0;
            w_strb_held   <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bid    <= '0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (s_axil_awvalid && !aw_held) begin
                aw_held     <= 1'b1;
                aw_id_held  <= s_axil_awid;
                aw_idx_held <= s_axil_awaddr[ADDR_W-1:2];
            end
            if (s_axil_wvalid && !w_held) begin
                w_held      <= 1'b1;
                w_data_held <= s_axil_wdata;
                w_strb_held <= s_axil_wstrb;
            end
            if (commit) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bid    <= aw_id_held;
                s_axil_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // Register storage, events and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            mask_reg  <= '0;
            event_reg <= '0;
            irq_o     <= 1'b0;
            for (int i = 0; i < NUM_SCR; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            if (wr_ok && aw_idx_held == IDX_W'(REG_OUT)) begin
                out_reg <= (out_reg & ~wr_mask[OUT_W-1:0]) | wr_bits[OUT_W-1:0];
            end
            if (wr_ok && aw_idx_held == IDX_W'(REG_IRQ_MASK)) begin
                mask_reg <= (mask_reg & ~wr_mask[IN_W-1:0]) | wr_bits[IN_W-1:0];
            end
            for (int i = 0; i < NUM_SCR; i++) begin
                if (wr_ok && aw_idx_held == IDX_W'(REG_SCRATCH0 + i)) begin
                    scratch[i] <= (scratch[i] & ~wr_mask) | wr_bits;
                end
            end
            // A new edge in the same cycle as a W1C keeps its bit set.
            event_reg <= (event_reg & ~ev_clr) | in_rise;
            irq_o     <= |(event_reg & mask_reg);
        end
    end

    assign out_o  = out_reg;
    assign ar_idx = s_axil_araddr[ADDR_W-1:2];

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (ar_idx >= IDX_W'(NUM_REGS)) begin
            rd_err = 1'b1;
        end else begin
            case (ar_idx)
                IDX_W'(REG_OUT):      rd_data = 32'(out_reg);
                IDX_W'(REG_IN):       rd_data = 32'(in_level);
                IDX_W'(REG_EVENT):    rd_data = 32'(event_reg);
                IDX_W'(REG_ID):       rd_data = VERSION;
                IDX_W'(REG_IRQ_MASK): rd_data = 32'(mask_reg);
                default: begin
                    for (int i = 0; i < NUM_SCR; i++) begin
                        if (ar_idx == IDX_W'(REG_SCRATCH0 + i)) begin
                            rd_data = scratch[i];
                        end
                    end
                end
            endcase
        end
    end

    // Read data channel: value captured at the AR handshake, held until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rid    <= '0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rlast  <= 1'b0;
        end else begin
            if (s_axil_arvalid && !s_axil_rvalid) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rid    <= s_axil_arid;
                s_axil_rdata  <= rd_data;
                s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                s_axil_rlast  <= 1'b1;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

endmodule
